// File: rtl/jtopll_pkg.sv
// rtl/jtopll_pkg.sv - shared types, timing defaults and helpers for the OPLL write sequencer
package jtopll_pkg;

    // Sequencer phases: address strobe, address settle, data strobe, data settle.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AWR   = 3'd1,
        ST_AWAIT = 3'd2,
        ST_DWR   = 3'd3,
        ST_DWAIT = 3'd4
    } wrseq_state_t;

    // Default bus timing, in cen ticks.
    localparam int DEF_WR_PULSE  = 2;
    localparam int DEF_ADDR_WAIT = 12;
    localparam int DEF_DATA_WAIT = 84;

    // One queued register write.
    typedef struct packed {
        logic [7:0] reg_num;
        logic [7:0] val;
    } wr_req_t;

    // A zero-length phase would collapse the bus protocol, so zero means one tick.
    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/jtopll_wrseq_fifo.sv
// rtl/jtopll_wrseq_fifo.sv - small request queue between the CPU side and the bus sequencer
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset (empties the queue)
//   push, push_data  enqueue one request; ignored while full
//   pop, pop_data    dequeue the head; pop_data shows the head combinationally
//   full, empty      occupancy flags
//   count            occupancy, one bit wider than the pointers
module jtopll_wrseq_fifo
    import jtopll_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  wr_req_t       push_data,
    input  logic          pop,
    output wr_req_t       pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    wr_req_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Guarded here so the queue can never overwrite or underflow, whatever the caller does.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jtopll_wrseq.sv
// rtl/jtopll_wrseq.sv - queues OPLL register writes and plays them out as timed address/data bus cycles
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cen                 clock enable; every bus phase is counted in cen ticks
//   req_valid/req_ready request handshake (accepted on any clk edge)
//   req_reg, req_val    OPLL register number and value
//   addr, dout          chip address line (0 = register select, 1 = data) and data bus
//   cs_n, wr_n          chip select and write strobe, active-low, always equal
//   busy                queue non-empty or a write sequence in progress
module jtopll_wrseq
    import jtopll_pkg::*;
#(
    parameter int WR_PULSE  = DEF_WR_PULSE,
    parameter int ADDR_WAIT = DEF_ADDR_WAIT,
    parameter int DATA_WAIT = DEF_DATA_WAIT,
    parameter int FIFO_AW   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_val,
    output logic       addr,
    output logic [7:0] dout,
    output logic       cs_n,
    output logic       wr_n,
    output logic       busy
);

    localparam int WP   = at_least_one(WR_PULSE);
    localparam int AWT  = at_least_one(ADDR_WAIT);
    localparam int DWT  = at_least_one(DATA_WAIT);
    localparam int MAXT = max3(WP, AWT, DWT);
    // The counter only ever holds (phase length - 1).
    localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

    localparam logic [CW-1:0] WP_LD  = CW'(WP - 1);
    localparam logic [CW-1:0] AWT_LD = CW'(AWT - 1);
    localparam logic [CW-1:0] DWT_LD = CW'(DWT - 1);

    wrseq_state_t    state;
    wrseq_state_t    state_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic            addr_q;
    logic            addr_nx;
    logic [7:0]      dout_q;
    logic [7:0]      dout_nx;
    logic            strobe_q;
    logic            strobe_nx;
    logic [7:0]      val_q;
    logic [7:0]      val_nx;
    logic            ready_en;

    logic            fifo_push;
    logic            fifo_pop;
    wr_req_t         fifo_in;
    wr_req_t         fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [FIFO_AW:0] fifo_count;

    // ready_en keeps req_ready low through reset and for the edge that releases it.
    assign req_ready = ready_en && !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign fifo_in   = '{reg_num: req_reg, val: req_val};

    jtopll_wrseq_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A single strobe register drives both cs_n and wr_n so they cannot skew.
    assign addr = addr_q;
    assign dout = dout_q;
    assign cs_n = ~strobe_q;
    assign wr_n = ~strobe_q;
    assign busy = (fifo_count != '0) || (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            addr_q   <= 1'b0;
            dout_q   <= '0;
            strobe_q <= 1'b0;
            val_q    <= '0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            addr_q   <= addr_nx;
            dout_q   <= dout_nx;
            strobe_q <= strobe_nx;
            val_q    <= val_nx;
            ready_en <= 1'b1;
        end
    end

    // Each phase loads (length - 1) on entry and leaves on the tick where the counter
    // reads zero. addr/dout are only updated on edges that also assert the strobe,
    // so they are stable for the whole low period and the following idle gap.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        addr_nx   = addr_q;
        dout_nx   = dout_q;
        strobe_nx = strobe_q;
        val_nx    = val_q;
        fifo_pop  = 1'b0;

        if (cen) begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        val_nx    = fifo_head.val;
                        addr_nx   = 1'b0;
                        dout_nx   = fifo_head.reg_num;
                        strobe_nx = 1'b1;
                        cnt_nx    = WP_LD;
                        state_nx  = ST_AWR;
                    end
                end
                ST_AWR: begin
                    if (cnt == '0) begin
                        strobe_nx = 1'b0;
                        cnt_nx    = AWT_LD;
                        state_nx  = ST_AWAIT;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                ST_AWAIT: begin
                    if (cnt == '0) begin
                        addr_nx   = 1'b1;
                        dout_nx   = val_q;
                        strobe_nx = 1'b1;
                        cnt_nx    = WP_LD;
                        state_nx  = ST_DWR;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                ST_DWR: begin
                    if (cnt == '0) begin
                        strobe_nx = 1'b0;
                        cnt_nx    = DWT_LD;
                        state_nx  = ST_DWAIT;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                ST_DWAIT: begin
                    if (cnt == '0) begin
                        cnt_nx   = '0;
                        state_nx = ST_IDLE;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                default: begin
                    strobe_nx = 1'b0;
                    cnt_nx    = '0;
                    state_nx  = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtopll_wrseq.sv
// tb/tb_jtopll_wrseq.sv - self-checking bench for jtopll_wrseq
module tb_jtopll_wrseq;

    localparam int P    = 2;
    localparam int AWT  = 12;
    localparam int DWT  = 84;
    localparam int XFER = P + AWT + P + DWT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_reg = 8'h00;
    logic [7:0] req_val = 8'h00;
    logic       addr;
    logic [7:0] dout;
    logic       cs_n;
    logic       wr_n;
    logic       busy;

    always #5 clk = ~clk;

    jtopll_wrseq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_reg   (req_reg),
        .req_val   (req_val),
        .addr      (addr),
        .dout      (dout),
        .cs_n      (cs_n),
        .wr_n      (wr_n),
        .busy      (busy)
    );

    typedef struct {logic a; logic [7:0] d; int s; int e;} bw_t;
    typedef struct {logic [7:0] r; logic [7:0] v; int s;} xf_t;
    typedef struct {logic [7:0] r; logic [7:0] v;} rq_t;
    typedef struct {logic [7:0] r; logic [7:0] v; int div; int exp_pulse; int exp_awt; int exp_dwt;} vec_t;

    int   errors = 0;
    int   checks = 0;
    bw_t  writes[$];
    xf_t  exp_x[$];
    rq_t  mq[$];
    int   tick = 0;
    int   m_tick = 0;
    int   next_pop = 0;
    bit   m_out = 1'b0;
    bit   mon_on = 1'b0;
    int   busy_fall = -1;
    int   cyc = 0;

    task automatic chk(input bit ok, input string nm, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic cen_pat(input int div);
        logic c;
        c = ((cyc % div) == 0);
        cyc++;
        return c;
    endfunction

    // Bus monitor: counts cen ticks, records every strobe pulse, checks bus invariants.
    initial begin
        bit         e_cen;
        bit         e_rst;
        bit         in_pulse;
        logic       pcs;
        logic       pa;
        logic [7:0] pd;
        logic       pb;
        int         ps;
        logic       sa;
        logic [7:0] sd;
        in_pulse = 1'b0; pcs = 1'b1; pa = 1'b0; pd = 8'h00; pb = 1'b0; ps = 0; sa = 1'b0; sd = 8'h00;
        forever begin
            @(posedge clk);
            e_cen = cen;
            e_rst = rst_n;
            if (e_cen) tick++;
            @(negedge clk);
            if (mon_on) begin
                chk(cs_n === wr_n, "cs_n_eq_wr_n", int'(cs_n), int'(wr_n));
                if (!e_rst) begin
                    in_pulse = 1'b0;
                end else begin
                    if (pcs === 1'b0) begin
                        chk(addr === pa, "addr_stable_while_cs_low", int'(addr), int'(pa));
                        chk(dout === pd, "dout_stable_while_cs_low", int'(dout), int'(pd));
                    end
                    if (!e_cen) begin
                        chk(cs_n === pcs, "cs_n_hold_without_cen", int'(cs_n), int'(pcs));
                        chk(addr === pa, "addr_hold_without_cen", int'(addr), int'(pa));
                        chk(dout === pd, "dout_hold_without_cen", int'(dout), int'(pd));
                    end
                    if (pcs && !cs_n) begin
                        in_pulse = 1'b1; ps = tick; sa = addr; sd = dout;
                    end
                    if (!pcs && cs_n && in_pulse) begin
                        writes.push_back('{sa, sd, ps, tick});
                        in_pulse = 1'b0;
                    end
                    if (pb && !busy) busy_fall = tick;
                end
            end
            pcs = cs_n; pa = addr; pd = dout; pb = busy;
        end
    end

    // One clk cycle of stimulus. The reference model: at most 4 waiting entries, the
    // head leaves the queue on a cen tick once the previous transfer (XFER ticks) has
    // returned to idle, and a push is only visible to the sequencer on the next edge.
    task automatic drive(input logic v, input logic [7:0] r, input logic [7:0] d,
                         input logic c, output bit acc);
        bit exp_rdy;
        req_valid = v; req_reg = r; req_val = d; cen = c; rst_n = 1'b1;
        exp_rdy = m_out && (mq.size() < 4);
        chk(req_ready === exp_rdy, "req_ready", int'(req_ready), int'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        #1;
        m_out = 1'b1;
        if (c) begin
            m_tick++;
            if (mq.size() > 0 && m_tick >= next_pop) begin
                exp_x.push_back('{mq[0].r, mq[0].v, m_tick});
                void'(mq.pop_front());
                next_pop = m_tick + XFER + 1;
            end
        end
        if (acc) mq.push_back('{r, d});
    endtask

    task automatic rst_edge(input logic c);
        rst_n = 1'b0; req_valid = 1'b0; cen = c;
        @(posedge clk);
        #1;
        if (c) m_tick++;
        mq.delete();
        exp_x.delete();
        m_out = 1'b0;
        next_pop = 0;
    endtask

    task automatic wait_idle(input int div, input int budget);
        bit a;
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            drive(1'b0, 8'h00, 8'h00, cen_pat(div), a);
            if (busy === 1'b0) done = 1'b1;
        end
        chk(done, "drain_within_budget", int'(done), 1);
        drive(1'b0, 8'h00, 8'h00, 1'b1, a);
        drive(1'b0, 8'h00, 8'h00, 1'b1, a);
    endtask

    task automatic check_transfers(input int pulse, input int awt, input int dwt);
        int nx;
        nx = exp_x.size();
        chk(writes.size() == 2 * nx, "bus_write_count", writes.size(), 2 * nx);
        if (writes.size() == 2 * nx) begin
            for (int i = 0; i < nx; i++) begin
                chk(writes[2*i].a == 1'b0, "addr_phase_addr", int'(writes[2*i].a), 0);
                chk(writes[2*i].d == exp_x[i].r, "addr_phase_dout", int'(writes[2*i].d), int'(exp_x[i].r));
                chk(writes[2*i].s == exp_x[i].s, "addr_phase_start_tick", writes[2*i].s, exp_x[i].s);
                chk(writes[2*i].e - writes[2*i].s == pulse, "addr_pulse_ticks", writes[2*i].e - writes[2*i].s, pulse);
                chk(writes[2*i+1].a == 1'b1, "data_phase_addr", int'(writes[2*i+1].a), 1);
                chk(writes[2*i+1].d == exp_x[i].v, "data_phase_dout", int'(writes[2*i+1].d), int'(exp_x[i].v));
                chk(writes[2*i+1].s - writes[2*i].e == awt, "addr_wait_ticks", writes[2*i+1].s - writes[2*i].e, awt);
                chk(writes[2*i+1].e - writes[2*i+1].s == pulse, "data_pulse_ticks", writes[2*i+1].e - writes[2*i+1].s, pulse);
                if (i > 0) begin
                    chk(writes[2*i].s - writes[2*i-1].e >= dwt, "transfer_spacing", writes[2*i].s - writes[2*i-1].e, dwt);
                end
            end
            if (nx > 0) begin
                chk(busy_fall - writes[2*nx-1].e == dwt, "data_wait_then_not_busy", busy_fall - writes[2*nx-1].e, dwt);
            end
        end
        writes.delete();
        exp_x.delete();
    endtask

    initial begin
        vec_t vecs[5];
        bit   a;
        int   i;
        int   guard;
        bit   saw_low;
        int   pct;

        // Reset state.
        rst_edge(1'b1);
        mon_on = 1'b1;
        rst_edge(1'b0);
        chk(cs_n === 1'b1, "reset_cs_n", int'(cs_n), 1);
        chk(wr_n === 1'b1, "reset_wr_n", int'(wr_n), 1);
        chk(addr === 1'b0, "reset_addr", int'(addr), 0);
        chk(dout === 8'h00, "reset_dout", int'(dout), 0);
        chk(busy === 1'b0, "reset_busy", int'(busy), 0);
        chk(req_ready === 1'b0, "reset_req_ready", int'(req_ready), 0);
        drive(1'b0, 8'h00, 8'h00, 1'b0, a);
        drive(1'b0, 8'h00, 8'h00, 1'b0, a);

        // Single writes, continuous and divided cen.
        vecs[0] = '{8'h10, 8'h55, 1, P, AWT, DWT};
        vecs[1] = '{8'h00, 8'hFF, 3, P, AWT, DWT};
        vecs[2] = '{8'hFF, 8'h00, 2, P, AWT, DWT};
        vecs[3] = '{8'hA5, 8'h5A, 1, P, AWT, DWT};
        vecs[4] = '{8'h3C, 8'hC3, 3, P, AWT, DWT};
        for (int k = 0; k < 5; k++) begin
            cyc = 0;
            drive(1'b1, vecs[k].r, vecs[k].v, cen_pat(vecs[k].div), a);
            chk(a, "single_push_accepted", int'(a), 1);
            wait_idle(vecs[k].div, 400 * vecs[k].div);
            check_transfers(vecs[k].exp_pulse, vecs[k].exp_awt, vecs[k].exp_dwt);
        end

        // Six back-to-back pushes with a full queue in between.
        i = 0; guard = 0; saw_low = 1'b0;
        while (i < 6 && guard < 300) begin
            if (req_ready === 1'b0) saw_low = 1'b1;
            drive(1'b1, 8'h20 + 8'(i), 8'h80 + 8'(i), 1'b1, a);
            if (a) i++;
            guard++;
        end
        chk(i == 6, "b2b_all_pushed", i, 6);
        chk(saw_low, "b2b_ready_dropped", int'(saw_low), 1);
        wait_idle(1, 1000);
        check_transfers(P, AWT, DWT);

        // Push and pop on the same edge with 3 entries queued.
        drive(1'b1, 8'h30, 8'h40, 1'b0, a);
        drive(1'b1, 8'h31, 8'h41, 1'b0, a);
        drive(1'b1, 8'h32, 8'h42, 1'b0, a);
        drive(1'b1, 8'h33, 8'h43, 1'b1, a);
        chk(req_ready === 1'b1, "pushpop_keeps_three", int'(req_ready), 1);
        drive(1'b1, 8'h34, 8'h44, 1'b0, a);
        drive(1'b0, 8'h00, 8'h00, 1'b0, a);
        chk(req_ready === 1'b0, "pushpop_then_full", int'(req_ready), 0);
        wait_idle(1, 1000);
        check_transfers(P, AWT, DWT);

        // Randomized traffic against the reference model.
        for (int rnd = 0; rnd < 4; rnd++) begin
            pct = (rnd == 0) ? 100 : (rnd == 1) ? 50 : (rnd == 2) ? 30 : 70;
            for (int n = 0; n < 40; n++) begin
                drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                      ($urandom_range(0, 99) < pct), a);
            end
            wait_idle(1, 1500);
            check_transfers(P, AWT, DWT);
        end

        // Reset during AWAIT with two entries still queued.
        drive(1'b1, 8'h40, 8'h50, 1'b1, a);
        drive(1'b1, 8'h41, 8'h51, 1'b1, a);
        drive(1'b1, 8'h42, 8'h52, 1'b1, a);
        guard = 0;
        while (writes.size() < 1 && guard < 50) begin
            drive(1'b0, 8'h00, 8'h00, 1'b1, a);
            guard++;
        end
        chk(writes.size() == 1, "awr_completed_before_reset", writes.size(), 1);
        drive(1'b0, 8'h00, 8'h00, 1'b1, a);
        rst_edge(1'b1);
        chk(cs_n === 1'b1, "abort_cs_n", int'(cs_n), 1);
        chk(busy === 1'b0, "abort_busy", int'(busy), 0);
        chk(req_ready === 1'b0, "abort_req_ready_in_reset", int'(req_ready), 0);
        for (int n = 0; n < 300; n++) drive(1'b0, 8'h00, 8'h00, 1'b1, a);
        chk(writes.size() == 1, "no_writes_after_abort", writes.size(), 1);
        chk(busy === 1'b0, "idle_after_abort", int'(busy), 0);
        writes.delete();

        // Reset while the address strobe is low.
        drive(1'b1, 8'h60, 8'h70, 1'b1, a);
        drive(1'b0, 8'h00, 8'h00, 1'b1, a);
        chk(cs_n === 1'b0, "awr_strobe_low", int'(cs_n), 0);
        rst_edge(1'b0);
        chk(cs_n === 1'b1, "abort_awr_cs_n", int'(cs_n), 1);
        chk(wr_n === 1'b1, "abort_awr_wr_n", int'(wr_n), 1);
        chk(dout === 8'h00, "abort_awr_dout", int'(dout), 0);
        for (int n = 0; n < 150; n++) drive(1'b0, 8'h00, 8'h00, 1'b1, a);
        chk(writes.size() == 0, "no_writes_after_awr_abort", writes.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
